// File: rtl/uart_rx_cmd_pkg.sv
// Shared definitions for the serial command path: command codes and the rx FSM encoding.
// The command codes are also consumed by the downstream command handler.
package uart_rx_cmd_pkg;

    localparam logic [3:0] CMD_LIMPAR   = 4'd1;
    localparam logic [3:0] CMD_CARREGAR = 4'd2;
    localparam logic [3:0] CMD_MOSTRAR  = 4'd4;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_EMIT
    } rx_state_t;

    function automatic logic is_known_cmd(input logic [3:0] c);
        return (c == CMD_LIMPAR) || (c == CMD_CARREGAR) || (c == CMD_MOSTRAR);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling baud counter, START/DATA/STOP FSM.
// o_done / o_ferr are single-cycle pulses; o_byte is valid while o_done is high.
module uart_rx_core
    import uart_rx_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clock,
    input  logic       i_resetn,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_done,
    output logic       o_ferr
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    r_sync;
    rx_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_done;
    logic          r_ferr;
    logic          w_rx_s;

    assign w_rx_s = r_sync[1];
    assign o_byte = r_shift;
    assign o_done = r_done;
    assign o_ferr = r_ferr;

    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_sync  <= 2'b11;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_rx};
            r_done <= 1'b0;
            r_ferr <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // Re-check at mid start bit so short low glitches are ignored.
                    if (r_cnt == HALF) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= w_rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd7) r_state <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (r_cnt == LAST) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_done  <= 1'b1;
                            r_state <= RX_EMIT;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= RX_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RX_EMIT: r_state <= RX_IDLE;
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_cmd.sv
// Serial front end of the command handler: decodes received bytes into a one-shot
// instrucao pulse and a held dado nibble, dropping and flagging bad frames/commands.
module uart_rx_cmd
    import uart_rx_cmd_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int PULSE_CYCLES = 1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       rx,
    output logic [3:0] instrucao,
    output logic [3:0] dado,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       cmd_err
);

    localparam int             CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int             PCW          = $clog2(PULSE_CYCLES + 1);
    localparam logic [PCW-1:0] PULSE_LEN    = PCW'(PULSE_CYCLES);

    logic [7:0]     w_byte;
    logic           w_done;
    logic           w_ferr;
    logic [3:0]     r_instr;
    logic [3:0]     r_dado;
    logic           r_bv;
    logic           r_fe;
    logic           r_ce;
    logic [PCW-1:0] r_pcnt;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .i_clock (clock),
        .i_resetn(resetn),
        .i_rx    (rx),
        .o_byte  (w_byte),
        .o_done  (w_done),
        .o_ferr  (w_ferr)
    );

    assign instrucao  = r_instr;
    assign dado       = r_dado;
    assign byte_valid = r_bv;
    assign frame_err  = r_fe;
    assign cmd_err    = r_ce;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_instr <= '0;
            r_dado  <= '0;
            r_bv    <= 1'b0;
            r_fe    <= 1'b0;
            r_ce    <= 1'b0;
            r_pcnt  <= '0;
        end else begin
            r_bv <= 1'b0;
            r_ce <= 1'b0;
            r_fe <= w_ferr;
            if (r_pcnt != '0) begin
                r_pcnt <= r_pcnt - PCW'(1);
                if (r_pcnt == PCW'(1)) r_instr <= '0;
            end
            // A newly accepted command overrides any countdown still in flight.
            if (w_done) begin
                if (is_known_cmd(w_byte[3:0])) begin
                    r_instr <= w_byte[3:0];
                    r_dado  <= w_byte[7:4];
                    r_pcnt  <= PULSE_LEN;
                    r_bv    <= 1'b1;
                end else begin
                    r_ce <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Directed bench for uart_rx_cmd at 16 clocks per bit; a negedge monitor counts output pulses.
module tb_uart_rx_cmd;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rx;
    logic [3:0] instrucao;
    logic [3:0] dado;
    logic       byte_valid;
    logic       frame_err;
    logic       cmd_err;

    int checks = 0;
    int errors = 0;

    int         bv_cnt, fe_cnt, ce_cnt, instr_cyc, excl_cnt;
    logic [3:0] first_instr, last_instr;

    uart_rx_cmd #(
        .CLK_FREQ    (16),
        .BAUD        (1),
        .PULSE_CYCLES(1)
    ) dut (
        .clock     (clk),
        .resetn    (resetn),
        .rx        (rx),
        .instrucao (instrucao),
        .dado      (dado),
        .byte_valid(byte_valid),
        .frame_err (frame_err),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_valid) begin
            if (bv_cnt == 0) first_instr = instrucao;
            last_instr = instrucao;
            bv_cnt = bv_cnt + 1;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (cmd_err) ce_cnt = ce_cnt + 1;
        if (instrucao != 4'h0) instr_cyc = instr_cyc + 1;
        if ((int'(byte_valid) + int'(frame_err) + int'(cmd_err)) > 1) excl_cnt = excl_cnt + 1;
    end

    task automatic clear_mon();
        bv_cnt = 0; fe_cnt = 0; ce_cnt = 0; instr_cyc = 0; excl_cnt = 0;
        first_instr = 4'h0; last_instr = 4'h0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        tick(n);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(b[i], 16);
        drive_bit(stop, 16);
        rx = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] partial;
        clear_mon();
        resetn = 1'b0;
        rx     = 1'b1;
        tick(3);
        chk("rst_outputs", {instrucao, dado, byte_valid, frame_err, cmd_err}, 32'h0);
        resetn = 1'b1;
        clear_mon();
        tick(100);
        chk("idle_pulses", bv_cnt + fe_cnt + ce_cnt + instr_cyc, 0);

        // 0x52: carregar, dado 5
        clear_mon();
        send_byte(8'h52, 1'b1);
        tick(20);
        chk("b52_bv", bv_cnt, 1);
        chk("b52_instr_at_bv", first_instr, 4'h2);
        chk("b52_instr_cycles", instr_cyc, 1);
        chk("b52_instr_after", instrucao, 4'h0);
        chk("b52_dado", dado, 4'h5);
        chk("b52_errs", fe_cnt + ce_cnt, 0);

        // 0x34 then 0x91 back-to-back
        clear_mon();
        send_byte(8'h34, 1'b1);
        send_byte(8'h91, 1'b1);
        tick(20);
        chk("b2b_bv", bv_cnt, 2);
        chk("b2b_first_instr", first_instr, 4'h4);
        chk("b2b_last_instr", last_instr, 4'h1);
        chk("b2b_instr_cycles", instr_cyc, 2);
        chk("b2b_dado", dado, 4'h9);

        // 0x73: unknown command 3
        clear_mon();
        send_byte(8'h73, 1'b1);
        tick(20);
        chk("b73_cmd_err", ce_cnt, 1);
        chk("b73_bv", bv_cnt, 0);
        chk("b73_instr_cycles", instr_cyc, 0);
        chk("b73_dado", dado, 4'h9);

        // 0x41 with bad stop bit, then 0x14
        clear_mon();
        send_byte(8'h41, 1'b0);
        tick(32);
        chk("b41_frame_err", fe_cnt, 1);
        chk("b41_bv_ce", bv_cnt + ce_cnt, 0);
        chk("b41_dado", dado, 4'h9);
        clear_mon();
        send_byte(8'h14, 1'b1);
        tick(20);
        chk("b14_bv", bv_cnt, 1);
        chk("b14_instr", first_instr, 4'h4);
        chk("b14_dado", dado, 4'h1);
        chk("b14_errs", fe_cnt + ce_cnt, 0);

        // 4-clock low glitch in IDLE
        clear_mon();
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 40);
        chk("glitch_pulses", bv_cnt + fe_cnt + ce_cnt + instr_cyc, 0);

        // reset during data bit 3 of a 0x22 frame
        partial = 8'h22;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) drive_bit(partial[i], 16);
        drive_bit(partial[3], 8);
        resetn = 1'b0;
        rx     = 1'b1;
        tick(3);
        chk("midrst_outputs", {instrucao, dado, byte_valid, frame_err, cmd_err}, 32'h0);
        resetn = 1'b1;
        tick(40);
        chk("midrst_no_pulse", bv_cnt + fe_cnt + ce_cnt + instr_cyc, 0);
        clear_mon();
        send_byte(8'h22, 1'b1);
        tick(20);
        chk("b22_bv", bv_cnt, 1);
        chk("b22_instr", first_instr, 4'h2);
        chk("b22_dado", dado, 4'h2);
        chk("b22_errs", fe_cnt + ce_cnt, 0);
        chk("exclusive_pulses", excl_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_cmd.md
Name: uart_rx_cmd

Overview:
- Upstream stage of the command handler: receives 8N1 serial bytes on a single RX line.
- Validates framing and splits each byte into a command nibble (instrucao, bits [3:0]) and a data nibble (dado, bits [7:4]).
- Presents them in the format the command handler consumes: instrucao as a one-shot pulse, dado as a held level.
- Bad frames and unknown commands are dropped and flagged.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD, clocks per bit (derived localparam; must be >= 4).
- PULSE_CYCLES, 1, number of clocks instrucao stays non-zero per accepted command.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- resetn  input  1  synchronous, active-low reset.
- rx  input  1  asynchronous serial line; idles high.
- instrucao  output  4  command nibble. Non-zero only during an accepted-command pulse, otherwise 0.
- dado  output  4  data nibble of the last accepted command; held.
- byte_valid  output  1  one-cycle pulse, coincident with the first cycle of the instrucao pulse.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- cmd_err  output  1  one-cycle pulse when the framed byte carries an unknown command.

Behaviour:
- Reset (resetn=0 at a rising edge):
  - Outputs: instrucao=0, dado=0, byte_valid=0, frame_err=0, cmd_err=0.
  - Internal: FSM to IDLE, counters cleared, synchronizer flops set to 1 (idle level).
  - Reset mid-frame aborts the frame silently; no error pulse.
- Synchronizer: rx passes through 2 flops; all FSM logic uses the synchronized value rx_s.
- FSM states: IDLE, START, DATA, STOP, EMIT.
  - IDLE: on rx_s=0 go to START and clear the bit-clock counter.
  - START: wait CLKS_PER_BIT/2 clocks (mid start bit), then re-sample.
    - rx_s=1: glitch; return to IDLE, no error.
    - rx_s=0: go to DATA with counter cleared and bit index 0.
  - DATA: every CLKS_PER_BIT clocks, sample rx_s into shift register, LSB first.
    - After bit index 7, go to STOP.
  - STOP: after CLKS_PER_BIT clocks, sample rx_s.
    - 0: pulse frame_err, byte discarded, go to IDLE. A held-low line then re-triggers START normally.
    - 1: go to EMIT.
  - EMIT (1 cycle): decode the byte.
    - Low nibble is 1 (limpar), 2 (carregar) or 4 (mostrar): dado<=byte[7:4]; instrucao<=byte[3:0] for PULSE_CYCLES clocks, then 0; byte_valid pulses once; go to IDLE.
    - Any other low nibble: cmd_err pulses once; dado and instrucao unchanged; go to IDLE.
- The pulse countdown runs independently of the FSM. A new frame may begin while instrucao is still active.
- If a second accepted byte arrives before the countdown ends, the new values overwrite and the countdown restarts.
- Latency: byte_valid rises 1 clock after the stop-bit sample edge, i.e. about 9.5 bit times after the start-bit falling edge plus 2 synchronizer clocks.
- Counter widths: $clog2(CLKS_PER_BIT) bits for the bit-clock counter, 3 bits for the bit index. No wrap beyond the terminal count; the counter clears on each bit boundary.
- At most one of byte_valid / frame_err / cmd_err is high in any cycle.

Decomposition:
- Shared package holds:
  - Command code constants CMD_LIMPAR=4'd1, CMD_CARREGAR=4'd2, CMD_MOSTRAR=4'd4, also used by the command handler.
  - The rx FSM state encoding.
- One natural sub-module: uart_rx_core.
  - Contains the synchronizer, baud counter and the START/DATA/STOP FSM.
  - Outputs an 8-bit byte plus rx_done and rx_ferr pulses.
- uart_rx_cmd wraps uart_rx_core and adds the EMIT decode, command filter and pulse stretcher.

Test Plan (CLK_FREQ=16, BAUD=1, so CLKS_PER_BIT=16):
- Reset held 3 clocks with rx=1 -> all outputs 0. Release, idle 100 clocks -> no pulses.
- Send byte 0x52 -> byte_valid one cycle; instrucao=4'h2 for exactly 1 clock then 0; dado=4'h5 held afterwards.
- Send 0x34, then 0x91 back-to-back -> two byte_valid pulses; instrucao 4 then 1; dado ends at 4'h9.
- Send 0x73 (command 3) -> cmd_err one cycle, no byte_valid; instrucao stays 0; dado keeps its previous value.
- Send 0x41 with stop bit forced 0 -> frame_err one cycle, no byte_valid, dado unchanged. The next good byte 0x14 is accepted.
- rx low glitch of 4 clocks in IDLE -> no activity. Then assert resetn=0 at data bit 3 of a frame -> outputs 0, FSM IDLE, no error pulse; the following frame 0x22 is received correctly.
